// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode encodings,
// FSM state encoding, default datapath width and the latched-operand record.
// No ports; imported by alu and alu_arbiter.
package alu_pkg;

    // Default (and only supported) operand/result width.
    localparam int WIDTH_DEF = 32;

    // ALU opcodes. Encodings 7 and 11-15 are unused and evaluate to zero.
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SLTU = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SRL  = 4'd10;

    // Arbiter FSM encoding: one cycle each of accept, execute, present.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Operands captured at accept; the ALU only ever sees this record.
    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [3:0]           op;
        logic                 id;
    } opnd_t;

    // True for every opcode the ALU implements.
    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SLTU,
            OP_XOR, OP_SLL, OP_SRA, OP_SRL: op_is_legal = 1'b1;
            default:                        op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/XOR, wrapping ADD/SUB, signed/unsigned compare, shifts.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows inputs every cycle.
// Ports: a, b   - operands (WIDTH bits)
//        op     - 4-bit opcode from alu_pkg
//        y      - result; unused opcodes give zero
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y
);

    localparam int SHW = $clog2(WIDTH);

    // Shift amount uses the whole of b: any set bit above the low SHW bits
    // means the shift is at least WIDTH and every data bit is shifted out.
    logic [SHW-1:0] shamt;
    logic           shift_oob;
    logic           lt_signed;
    logic           lt_unsigned;

    assign shamt       = b[SHW-1:0];
    assign shift_oob   = |b[WIDTH-1:SHW];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SLTU: y = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = shift_oob ? '0 : (a << shamt);
            OP_SRL:  y = shift_oob ? '0 : (a >> shamt);
            OP_SRA:  y = shift_oob ? {WIDTH{a[WIDTH-1]}}
                                   : $unsigned($signed(a) >>> shamt);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU; one operation in flight.
// Latency: handshake in cycle c, resp_valid high in cycle c+2; one op per 3 cycles.
// Backpressure: both reqN_ready low outside IDLE; response held until resp_ready.
// Ports: clk, rst (async, active-high)
//        reqN_valid/reqN_ready/reqN_a/reqN_b/reqN_op - requester N (N = 0, 1)
//        resp_valid/resp_ready/resp_data/resp_id     - result channel
//        resp_err - illegal-opcode flag, present only with ALU_ARB_OPCHECK_EN
// Build option: define ALU_ARB_OPCHECK_EN to add opcode checking and resp_err.
// Only WIDTH = 32 is supported.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id
`ifdef ALU_ARB_OPCHECK_EN
    ,
    output logic             resp_err
`endif
);

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    opnd_t            opnd;
    logic             gnt_any;
    logic             gnt_id;
    logic             accept;
    logic [WIDTH-1:0] alu_y;

    // Grant: a lone requester wins outright; under contention the one not
    // served last wins. last_grant resets to 1 so req0 wins the first tie.
    assign gnt_any = req0_valid | req1_valid;
    assign gnt_id  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_any) begin
                    accept     = 1'b1;
                    req0_ready = ~gnt_id;
                    req1_ready = gnt_id;
                    state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            opnd       <= '0;
        end else if (accept) begin
            last_grant <= gnt_id;
            opnd.a     <= gnt_id ? req1_a  : req0_a;
            opnd.b     <= gnt_id ? req1_b  : req0_b;
            opnd.op    <= gnt_id ? req1_op : req0_op;
            opnd.id    <= gnt_id;
        end
    end

    // The single ALU sees only the registered operands, so the result always
    // lands one cycle after accept regardless of requester input changes.
    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a  (opnd.a),
        .b  (opnd.b),
        .op (opnd.op),
        .y  (alu_y)
    );

    // Response register: loaded in EXEC, held through HOLD until taken.
    // A reset during EXEC returns to IDLE, so the in-flight result is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
        end else if (state == ST_EXEC) begin
            resp_valid <= 1'b1;
            resp_data  <= alu_y;
            resp_id    <= opnd.id;
        end else if ((state == ST_HOLD) && resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    // Error flag lives exactly as long as the response it describes; the ALU
    // already yields zero for unused opcodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_err <= 1'b0;
        end else if (state == ST_EXEC) begin
            resp_err <= ~op_is_legal(opnd.op);
        end else if ((state == ST_HOLD) && resp_ready) begin
            resp_err <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0_valid / req1_valid  input  1  requester i presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts requester i this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
REQ-007 req0_op / req1_op  input  4  ALU opcode: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 SLTU, 6 XOR, 8 SLL, 9 SRA, 10 SRL.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer takes result.
REQ-010 resp_data  output  WIDTH  result.
REQ-011 resp_id  output  1  index of the requester that owns resp_data.
REQ-012 resp_err  output  1  illegal-opcode flag; present only under ALU_ARB_OPCHECK_EN.

Function
REQ-013 Three-state FSM: IDLE, EXEC, HOLD.
REQ-014 IDLE: grant is combinational; reqN_ready = 1 only for the granted requester and only in IDLE.
REQ-015 Grant with one valid requester: that requester; with both valid: the requester not granted last (round-robin).
REQ-016 Accept (valid & ready) latches a, b, op and id into operand registers; IDLE->EXEC; last_grant <= id.
REQ-017 EXEC: one shared ALU evaluates the latched operands; result registered into resp_data; resp_valid <= 1; EXEC->HOLD.
REQ-018 Latency: accept at edge N, resp_valid high after edge N+2; no bypass.
REQ-019 HOLD: resp_data, resp_id and resp_valid stay stable until resp_ready = 1; that cycle is the handshake; next edge resp_valid <= 0, HOLD->IDLE.
REQ-020 Both req_ready = 0 in EXEC and HOLD; maximum throughput is one operation per 3 cycles.
REQ-021 Arithmetic: ADD/SUB wrap modulo 2^32; SLT is signed and SLTU unsigned, result 0 or 1 zero-extended; shifts use the full b value (b >= 32 gives 0, or sign-fill for SRA); OR is bitwise; opcodes 7 and 11-15 give 0.
REQ-022 A requester dropping valid before ready: no accept, no state change; a valid held during EXEC/HOLD is served in a later IDLE.

Reset
REQ-023 rst asserted in any state -> IDLE immediately; resp_valid = 0; resp_data = 0; resp_id = 0; resp_err = 0; operand registers = 0; last_grant = 1, so req0 wins first contention.
REQ-024 An in-flight operation is discarded, with no response after reset release.

Configuration
REQ-025 Macro ALU_ARB_OPCHECK_EN defined: opcodes 7 and 11-15 are accepted normally, produce resp_data = 0 with resp_err = 1 for that response only, and resp_err clears with resp_valid.
REQ-026 Macro undefined: no resp_err port and no opcode checking; illegal opcodes return 0.

Structure
REQ-027 Shared package alu_pkg holds the opcode localparams (OP_AND..OP_SRL), the FSM state encoding (2 bits) and WIDTH default.
REQ-028 One sub-module: existing combinational alu instance, single copy, fed only from the operand registers.

Verification
REQ-029 req0 ADD a=5 b=7 alone -> req0_ready=1 same cycle; resp_valid 2 cycles later, resp_data=12, resp_id=0.
REQ-030 Both valid after reset: req0 SUB 10,3 and req1 XOR 0xF0,0xFF -> req0 first (7, id 0), then req1 (0x0F, id 1); next contention grants req0 only if req1 last.
REQ-031 resp_ready held low 5 cycles in HOLD -> resp_data/resp_id constant, both req_ready=0; release -> resp_valid drops next edge.
REQ-032 SRA a=0x80000000 b=4 -> 0xF8000000; SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0; SLL b=40 -> 0.
REQ-033 rst pulsed during EXEC -> resp_valid stays 0, no response emitted, next req1 accepted in IDLE after release.
REQ-034 With ALU_ARB_OPCHECK_EN, req1 op=12 -> resp_data=0, resp_err=1, resp_id=1; following ADD response has resp_err=0.
